mem_scan_engine: RTL and testbench
==================================

# mem_scan_engine

Parametrised memory-window scan master for the DA_VINCI memory bus. It replaces fixed-window `$writememh` dumps with a cycle-accurate scanner that runs in-system. On START it reads a configurable window of words, ascending or descending. For each word it streams the word out, accumulates a wrapping checksum and can check the Fibonacci recurrence. It sits between the bench/controller and the memory port, and drives ADDR/READ/WRITE the same way the processor does.

## Interface
- DATA_WIDTH, 32, memory word width
- ADDR_WIDTH, 26, memory address width (64M words)
- COUNT_WIDTH, 16, width of word count and index
- RD_LATENCY, 1, cycles READ is held before DATA_IN is sampled (>=1)

- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- START  in  1  scan request; accepted only when not BUSY
- BASE_ADDR  in  ADDR_WIDTH  first address; sampled on accepted START
- WORD_COUNT  in  COUNT_WIDTH  words to scan; sampled on accepted START
- DESCEND  in  1  1 = address decrements; sampled on accepted START
- FIB_CHECK  in  1  1 = enable recurrence check; sampled on accepted START
- ADDR  out  ADDR_WIDTH  memory address
- READ  out  1  memory read strobe
- WRITE  out  1  memory write strobe, constant 0
- DATA_IN  in  DATA_WIDTH  memory read data
- WORD_OUT  out  DATA_WIDTH  last captured word
- WORD_VALID  out  1  one-cycle pulse per captured word
- WORD_IDX  out  COUNT_WIDTH  index of WORD_OUT, 0-based
- CHECKSUM  out  DATA_WIDTH  sum of captured words, mod 2^DATA_WIDTH
- BUSY  out  1  scan in progress
- DONE  out  1  scan complete; held until next accepted START or reset
- FAIL  out  1  recurrence mismatch seen; sticky for the scan
- FAIL_IDX  out  COUNT_WIDTH  index of first mismatch

## Operation
- Reset: all outputs 0 and state IDLE. Reset takes effect immediately, including mid-scan; no partial DONE is produced.
- States: IDLE, RD, GAP, FIN.
- IDLE/FIN, START=1:
  - Latch inputs; clear CHECKSUM, FAIL, FAIL_IDX, WORD_IDX and DONE.
  - WORD_COUNT==0: go to FIN; DONE rises next cycle with CHECKSUM=0.
  - Otherwise go to RD; BUSY=1.
- RD:
  - READ=1 with ADDR held at the current address for RD_LATENCY cycles.
  - DATA_IN is sampled at the edge ending the last RD cycle.
  - Then go to GAP.
- GAP:
  - READ=0. WORD_VALID=1, WORD_OUT = captured word, WORD_IDX = its index.
  - CHECKSUM has been updated at the capture edge.
  - Address steps +1 (DESCEND=0) or -1 (DESCEND=1), mod 2^ADDR_WIDTH. The address wraps: 0x3FFFFFF+1 = 0, 0-1 = 0x3FFFFFF.
  - If more words remain, go to RD; else go to FIN.
- FIN: BUSY=0, DONE=1, READ=0; results are held.
- Fibonacci check (FIB_CHECK=1):
  - Applies to index i>=2. Expected value = w[i-1]+w[i-2] mod 2^DATA_WIDTH.
  - On the first mismatch, FAIL=1 and FAIL_IDX=i. Later mismatches do not change FAIL_IDX. The scan always completes.
- FIB_CHECK=0: FAIL stays 0.
- START while BUSY: ignored, with no effect on the scan in progress.

## Timing
- Accepted START sampled at edge 0: READ is high in cycles 1..RD_LATENCY.
- Each word takes RD_LATENCY+1 cycles, and there is always one READ-low cycle between words.
- N words: the last WORD_VALID is in cycle N*(RD_LATENCY+1). BUSY falls and DONE rises in cycle N*(RD_LATENCY+1)+1.
- CHECKSUM, FAIL and FAIL_IDX are final in the same cycle that DONE rises.
- ADDR is stable for the whole RD run. ADDR is 0 in IDLE and holds the last value in GAP and FIN.
- START accepted in FIN: DONE falls at the next edge, and READ rises in the same cycle.

## Test plan
- Ascending Fibonacci window:
  - Stimulus: memory 0x01000000..0x0100000F = 0,1,1,2,...,610; BASE=0x01000000, COUNT=16, FIB_CHECK=1, RD_LATENCY=1.
  - Required: 16 WORD_VALID pulses carrying the words in order; CHECKSUM=0x63C; FAIL=0; DONE in cycle 33.
- Descending window:
  - Stimulus: reverse Fibonacci stored 0x03FFFFFF downward; BASE=0x03FFFFFF, COUNT=16, DESCEND=1.
  - Required: ADDR sequence 0x3FFFFFF,0x3FFFFFE,...,0x3FFFFF0; FAIL=0; CHECKSUM=0x63C.
- Corruption:
  - Stimulus: same as the ascending case, with word 7 changed from 13 to 14 and word 9 also corrupted.
  - Required: FAIL=1, FAIL_IDX=7, CHECKSUM=0x63D plus the word 9 delta; the scan still completes.
- Wrap and zero count:
  - Stimulus: BASE=0x3FFFFFE, COUNT=4, ascending.
  - Required: ADDR sequence 0x3FFFFFE,0x3FFFFFF,0x0000000,0x0000001.
  - Stimulus: COUNT=0.
  - Required: no READ; DONE in cycle 1; CHECKSUM=0.
- Latency and overlap:
  - Stimulus: RD_LATENCY=3, COUNT=4.
  - Required: READ high for 3 cycles, then low for 1; DONE in cycle 17.
  - Stimulus: START pulsed again at cycle 5.
  - Required: ignored; results identical to the run without the second START.
- Reset mid-scan:
  - Stimulus: assert RST in cycle 6 of a 16-word scan, asynchronously off-edge.
  - Required: all outputs 0 immediately; WRITE never 1. A new START after release runs a clean, full scan.

Source files
------------

// File: rtl/mem_scan_engine.sv
// Memory-window scan master: reads WORD_COUNT words from BASE_ADDR (up or down),
// streams each word, keeps a wrapping checksum and optionally checks the Fibonacci recurrence.
//   state | meaning
//   IDLE  | post-reset, waiting for START
//   RD    | READ held on current address for RD_LATENCY cycles, data captured at last edge
//   GAP   | READ low, captured word presented, address steps if more words remain
//   FIN   | scan complete, results held until next START
module mem_scan_engine #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 26,
  parameter int COUNT_WIDTH = 16,
  parameter int RD_LATENCY  = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic [ADDR_WIDTH-1:0]  i_base_addr,
  input  logic [COUNT_WIDTH-1:0] i_word_count,
  input  logic                   i_descend,
  input  logic                   i_fib_check,
  output logic [ADDR_WIDTH-1:0]  o_addr,
  output logic                   o_read,
  output logic                   o_write,
  input  logic [DATA_WIDTH-1:0]  i_data_in,
  output logic [DATA_WIDTH-1:0]  o_word_out,
  output logic                   o_word_valid,
  output logic [COUNT_WIDTH-1:0] o_word_idx,
  output logic [DATA_WIDTH-1:0]  o_checksum,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_fail,
  output logic [COUNT_WIDTH-1:0] o_fail_idx
);

  localparam int LAT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RD_LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_GAP, S_FIN} state_t;

  state_t                 r_state, w_next;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [COUNT_WIDTH-1:0] r_remain;
  logic [COUNT_WIDTH-1:0] r_cap_idx;
  logic [LAT_W-1:0]       r_lat_cnt;
  logic                   r_descend;
  logic                   r_fib;
  logic [DATA_WIDTH-1:0]  r_prev1, r_prev2;
  logic [DATA_WIDTH-1:0]  r_word_out;
  logic [COUNT_WIDTH-1:0] r_word_idx;
  logic [DATA_WIDTH-1:0]  r_checksum;
  logic                   r_fail;
  logic [COUNT_WIDTH-1:0] r_fail_idx;

  logic                   w_accept;
  logic                   w_capture;
  logic                   w_more;
  logic                   w_fib_bad;
  logic [DATA_WIDTH-1:0]  w_fib_exp;

  assign w_accept  = i_start && ((r_state == S_IDLE) || (r_state == S_FIN));
  assign w_capture = (r_state == S_RD) && (r_lat_cnt == '0);
  assign w_more    = (r_remain != '0);
  assign w_fib_exp = r_prev1 + r_prev2;
  assign w_fib_bad = r_fib && (r_cap_idx >= COUNT_WIDTH'(2)) && (i_data_in != w_fib_exp);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    o_read       = 1'b0;
    o_word_valid = 1'b0;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    case (r_state)
      S_IDLE, S_FIN: begin
        o_done = (r_state == S_FIN);
        if (w_accept) w_next = (i_word_count == '0) ? S_FIN : S_RD;
      end
      S_RD: begin
        o_read = 1'b1;
        o_busy = 1'b1;
        if (w_capture) w_next = S_GAP;
      end
      S_GAP: begin
        o_word_valid = 1'b1;
        o_busy       = 1'b1;
        w_next       = w_more ? S_RD : S_FIN;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_addr     <= '0;
      r_remain   <= '0;
      r_cap_idx  <= '0;
      r_lat_cnt  <= '0;
      r_descend  <= 1'b0;
      r_fib      <= 1'b0;
      r_prev1    <= '0;
      r_prev2    <= '0;
      r_word_out <= '0;
      r_word_idx <= '0;
      r_checksum <= '0;
      r_fail     <= 1'b0;
      r_fail_idx <= '0;
    end else if (w_accept) begin
      r_addr     <= i_base_addr;
      r_remain   <= i_word_count;
      r_cap_idx  <= '0;
      r_lat_cnt  <= LAT_LOAD;
      r_descend  <= i_descend;
      r_fib      <= i_fib_check;
      r_word_idx <= '0;
      r_checksum <= '0;
      r_fail     <= 1'b0;
      r_fail_idx <= '0;
    end else if (w_capture) begin
      r_word_out <= i_data_in;
      r_word_idx <= r_cap_idx;
      r_cap_idx  <= r_cap_idx + 1'b1;
      r_remain   <= r_remain - 1'b1;
      r_checksum <= r_checksum + i_data_in;
      r_prev2    <= r_prev1;
      r_prev1    <= i_data_in;
      // only the first mismatch is recorded
      if (w_fib_bad && !r_fail) begin
        r_fail     <= 1'b1;
        r_fail_idx <= r_cap_idx;
      end
    end else if (r_state == S_RD) begin
      r_lat_cnt <= r_lat_cnt - 1'b1;
    end else if ((r_state == S_GAP) && w_more) begin
      r_addr    <= r_descend ? (r_addr - 1'b1) : (r_addr + 1'b1);
      r_lat_cnt <= LAT_LOAD;
    end
  end

  assign o_addr     = r_addr;
  assign o_write    = 1'b0;
  assign o_word_out = r_word_out;
  assign o_word_idx = r_word_idx;
  assign o_checksum = r_checksum;
  assign o_fail     = r_fail;
  assign o_fail_idx = r_fail_idx;

endmodule

// File: tb/tb_mem_scan_engine.sv
// Scoreboard bench for mem_scan_engine: driver pushes model expectations per scan,
// a negedge monitor pops and compares words, read timing and final results.
module tb_mem_scan_engine;
  localparam int DW  = 32;
  localparam int AW  = 26;
  localparam int CW  = 16;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [CW-1:0] word_count = '0;
  logic          descend = 1'b0;
  logic          fib_check = 1'b0;
  logic [DW-1:0] data_in;
  logic [AW-1:0] o_addr;
  logic          o_read, o_write, o_word_valid, o_busy, o_done, o_fail;
  logic [DW-1:0] o_word_out, o_checksum;
  logic [CW-1:0] o_word_idx, o_fail_idx;

  mem_scan_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .COUNT_WIDTH(CW), .RD_LATENCY(LAT)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_base_addr(base_addr),
    .i_word_count(word_count), .i_descend(descend), .i_fib_check(fib_check),
    .o_addr(o_addr), .o_read(o_read), .o_write(o_write), .i_data_in(data_in),
    .o_word_out(o_word_out), .o_word_valid(o_word_valid), .o_word_idx(o_word_idx),
    .o_checksum(o_checksum), .o_busy(o_busy), .o_done(o_done), .o_fail(o_fail),
    .o_fail_idx(o_fail_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // memory: a 64-word window of test data, hashed content elsewhere
  logic [AW-1:0] win_base = '0;
  logic [DW-1:0] win_data [64];

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    logic [AW-1:0] off;
    off = a - win_base;
    if (off < AW'(64)) return win_data[off[5:0]];
    return {6'h0, a} ^ 32'hA5A5_0000;
  endfunction

  assign data_in = o_read ? mem_word(o_addr) : 32'hDEAD_BEEF;

  typedef struct {
    logic [DW-1:0] word;
    logic [CW-1:0] idx;
    logic [AW-1:0] addr;
    int            vcyc;
    int            rcyc;
  } wexp_t;
  typedef struct {
    int            dcyc;
    logic [DW-1:0] sum;
    logic          fail;
    logic [CW-1:0] fidx;
  } sexp_t;

  wexp_t wq[$];
  sexp_t sq[$];

  // monitor
  int    run = 0;
  logic  prev_done = 1'b0;
  wexp_t mw;
  sexp_t ms;

  always @(negedge clk) begin
    if (rst) begin
      run = 0;
      prev_done = 1'b0;
    end else begin
      chk("write_low", {63'd0, o_write}, 64'd0);
      if (o_read) begin
        if (wq.size() == 0) chk("read_unexpected", 64'd1, 64'd0);
        else begin
          if (run == 0) begin
            chk("read_start_cyc", 64'(cyc), 64'(wq[0].rcyc));
            chk("done_low_in_read", {63'd0, o_done}, 64'd0);
          end
          chk("read_addr", 64'(o_addr), 64'(wq[0].addr));
        end
        run++;
      end else if (run != 0) begin
        chk("read_len", 64'(run), 64'(LAT));
        run = 0;
      end
      if (o_word_valid) begin
        if (wq.size() == 0) chk("valid_unexpected", 64'd1, 64'd0);
        else begin
          mw = wq.pop_front();
          chk("word_out", 64'(o_word_out), 64'(mw.word));
          chk("word_idx", 64'(o_word_idx), 64'(mw.idx));
          chk("gap_addr", 64'(o_addr), 64'(mw.addr));
          chk("valid_cyc", 64'(cyc), 64'(mw.vcyc));
          chk("busy_in_gap", {63'd0, o_busy}, 64'd1);
        end
      end
      if (sq.size() != 0 && cyc == sq[0].dcyc) begin
        ms = sq.pop_front();
        chk("done_cyc", {63'd0, o_done}, 64'd1);
        chk("busy_at_done", {63'd0, o_busy}, 64'd0);
        chk("checksum", 64'(o_checksum), 64'(ms.sum));
        chk("fail", {63'd0, o_fail}, {63'd0, ms.fail});
        chk("fail_idx", 64'(o_fail_idx), 64'(ms.fidx));
        chk("words_left", 64'(wq.size()), 64'd0);
      end else if (o_done && !prev_done) begin
        chk("done_unexpected", 64'd1, 64'd0);
      end
      prev_done = o_done;
    end
  end

  // mode: 0 clean fib (0,1), 1 fib with words 7 and 9 corrupted, 2 random fib maybe corrupted, 3 random data
  task automatic issue(input logic [AW-1:0] base, input int n, input bit desc, input bit fib, input int mode);
    logic [DW-1:0] seq [64];
    logic [DW-1:0] w [64];
    logic [AW-1:0] a;
    logic [DW-1:0] sum;
    logic          fl;
    logic [CW-1:0] fi;
    int            e;
    sexp_t         s;
    wexp_t         we;
    seq[0] = (mode < 2) ? 32'd0 : $urandom;
    seq[1] = (mode < 2) ? 32'd1 : $urandom;
    for (int k = 2; k < 64; k++) seq[k] = seq[k-1] + seq[k-2];
    if (mode == 1) begin
      seq[7] = seq[7] + 32'd1;
      seq[9] = seq[9] + 32'd3;
    end else if (mode == 2 && n > 2 && $urandom_range(0, 1) == 1) begin
      int ci;
      ci = $urandom_range(2, n - 1);
      seq[ci] = seq[ci] ^ (32'd1 << $urandom_range(0, 31));
    end else if (mode == 3) begin
      for (int k = 0; k < 64; k++) seq[k] = $urandom;
    end
    @(negedge clk);
    if (!desc) begin
      win_base = base;
      for (int k = 0; k < 64; k++) win_data[k] = seq[k];
    end else begin
      win_base = base - AW'(63);
      for (int k = 0; k < 64; k++) win_data[63-k] = seq[k];
    end
    e = cyc + 1;
    sum = '0; fl = 1'b0; fi = '0;
    for (int i = 0; i < n; i++) begin
      a = desc ? (base - AW'(i)) : (base + AW'(i));
      w[i] = mem_word(a);
      sum = sum + w[i];
      if (fib && i >= 2 && !fl && w[i] != w[i-1] + w[i-2]) begin
        fl = 1'b1;
        fi = CW'(i);
      end
      we.word = w[i]; we.idx = CW'(i); we.addr = a;
      we.vcyc = e - 1 + (i + 1) * (LAT + 1);
      we.rcyc = e + i * (LAT + 1);
      wq.push_back(we);
    end
    s.dcyc = e + n * (LAT + 1); s.sum = sum; s.fail = fl; s.fidx = fi;
    sq.push_back(s);
    start = 1'b1; base_addr = base; word_count = CW'(n); descend = desc; fib_check = fib;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int n);
    for (int t = 0; t < n * (LAT + 1) + 20; t++) begin
      @(posedge clk);
      if (sq.size() == 0) break;
    end
    if (sq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scan_timeout actual=pending required=done");
      sq.delete();
      wq.delete();
    end
  endtask

  task automatic run_scan(input logic [AW-1:0] base, input int n, input bit desc, input bit fib,
                          input int mode, input bit b2b, input bit ovl);
    if (!b2b) repeat ($urandom_range(1, 4)) @(negedge clk);
    issue(base, n, desc, fib, mode);
    if (ovl && n >= 2) begin
      repeat (3) @(negedge clk);
      start = 1'b1; base_addr = AW'($urandom); word_count = CW'($urandom_range(0, 30));
      descend = ~desc; fib_check = ~fib;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done(n);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_addr"}, 64'(o_addr), 64'd0);
    chk({tag, "_word_out"}, 64'(o_word_out), 64'd0);
    chk({tag, "_checksum"}, 64'(o_checksum), 64'd0);
    chk({tag, "_idx"}, 64'({o_word_idx, o_fail_idx}), 64'd0);
    chk({tag, "_ctrl"}, 64'({o_read, o_write, o_word_valid, o_busy, o_done, o_fail}), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check_zero_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    run_scan(26'h100_0000, 16, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    run_scan(26'h3FF_FFFF, 16, 1'b1, 1'b1, 0, 1'b0, 1'b0);
    run_scan(26'h100_0000, 16, 1'b0, 1'b1, 1, 1'b0, 1'b0);
    run_scan(26'h3FF_FFFE, 4, 1'b0, 1'b0, 3, 1'b0, 1'b0);
    run_scan(26'h000_0001, 3, 1'b1, 1'b0, 3, 1'b1, 1'b0);
    run_scan(26'h123_4567, 0, 1'b0, 1'b0, 3, 1'b0, 1'b0);
    run_scan(26'h000_0010, 4, 1'b0, 1'b1, 0, 1'b1, 1'b1);
    run_scan(26'h000_0010, 4, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    // asynchronous reset mid-scan, off the clock edge
    issue(26'h100_0000, 16, 1'b0, 1'b1, 0);
    repeat (4) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_zero_outputs("midrst");
    wq.delete();
    sq.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_scan(26'h100_0000, 16, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    for (int r = 0; r < 30; r++) begin
      logic [AW-1:0] b;
      b = ($urandom_range(0, 3) == 0) ? AW'(26'h3FF_FFF0 + $urandom_range(0, 31)) : AW'($urandom);
      run_scan(b, ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 20), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
    end
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
